// File: rtl/gyro_tilt_integrator_if.sv
// Rate-in / tilt-out bundle for gyro_tilt_integrator.
// master: rate source and tilt consumer side; slave: the integrator.
interface gyro_tilt_integrator_if #(
    parameter int CHANNELS  = 3,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24
);
    logic                          DIN_VLD;
    logic [CHANNELS*WIDTH-1:0]     DIN;
    logic                          ZERO;
    logic [CHANNELS*ACC_WIDTH-1:0] TILT;
    logic                          TILT_VLD;
    logic [CHANNELS-1:0]           SAT;
    logic                          BUSY;

    modport master (
        output DIN_VLD, DIN, ZERO,
        input  TILT, TILT_VLD, SAT, BUSY
    );

    modport slave (
        input  DIN_VLD, DIN, ZERO,
        output TILT, TILT_VLD, SAT, BUSY
    );
endinterface

// File: rtl/gyro_tilt_integrator.sv
// Multi-channel gyro tilt estimator: per-tick snapshot of the rate words,
// power-of-two moving average, signed deadband, saturating integration.
// Channels are processed one per cycle by a small IDLE/CALC/DONE FSM.
module gyro_tilt_integrator #(
    parameter int CHANNELS  = 3,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int AVG_LOG2  = 4,
    parameter int TICK_DIV  = 50000,
    parameter int DB_LO     = -42,
    parameter int DB_HI     = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    gyro_tilt_integrator_if.slave bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = WIDTH + AVG_LOG2;
    localparam int AW1   = ACC_WIDTH + 1;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int KW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                      state;
    logic [KW-1:0]               k;
    logic [PW-1:0]               ptr;
    logic [CW-1:0]               cnt;
    logic                        tick;

    logic signed [WIDTH-1:0]     din_ch [CHANNELS];
    logic signed [WIDTH-1:0]     samp   [CHANNELS];
    logic signed [WIDTH-1:0]     snap   [CHANNELS];
    logic signed [WIDTH-1:0]     win    [CHANNELS][DEPTH];
    logic signed [SW-1:0]        sum    [CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc    [CHANNELS];

    logic [CHANNELS*ACC_WIDTH-1:0] tilt_q;
    logic                          tilt_vld_q;
    logic [CHANNELS-1:0]           sat_q;
    logic                          busy_q;

    logic signed [WIDTH-1:0]     cur_snap, cur_old, avg, inc;
    logic signed [SW-1:0]        sum_new, sum_shift;
    logic signed [AW1-1:0]       acc_wide;
    logic signed [ACC_WIDTH-1:0] acc_new;
    logic                        sat_hit;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // Unpack the flat rate bus into per-channel signed words.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            din_ch[i] = bus.DIN[i*WIDTH +: WIDTH];
        end
    end

    // Datapath for the channel currently in CALC: window update, average, deadband, clamp.
    always_comb begin
        cur_snap  = snap[k];
        cur_old   = win[k][ptr];
        sum_new   = sum[k] + SW'(cur_snap) - SW'(cur_old);
        sum_shift = sum_new >>> AVG_LOG2;
        avg       = sum_shift[WIDTH-1:0];
        if ((int'(avg) > DB_LO) && (int'(avg) < DB_HI)) begin
            inc = '0;
        end else begin
            inc = avg;
        end
        acc_wide = AW1'(acc[k]) + AW1'(inc);
        sat_hit  = (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]);
        if (!sat_hit) begin
            acc_new = acc_wide[ACC_WIDTH-1:0];
        end else if (acc_wide[ACC_WIDTH]) begin
            acc_new = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            acc_new = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    // Tick counter, sample register, FSM and all per-channel state; ZERO overrides everything but samp.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            k          <= '0;
            ptr        <= '0;
            cnt        <= '0;
            tilt_q     <= '0;
            tilt_vld_q <= 1'b0;
            sat_q      <= '0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                samp[i] <= '0;
                snap[i] <= '0;
                sum[i]  <= '0;
                acc[i]  <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            tilt_vld_q <= 1'b0;
            if (bus.ZERO) begin
                state  <= IDLE;
                k      <= '0;
                ptr    <= '0;
                cnt    <= '0;
                tilt_q <= '0;
                sat_q  <= '0;
                busy_q <= 1'b0;
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    sum[i] <= '0;
                    acc[i] <= '0;
                    for (int unsigned j = 0; j < DEPTH; j++) begin
                        win[i][j] <= '0;
                    end
                end
            end else begin
                if (bus.DIN_VLD) begin
                    samp <= din_ch;
                end
                cnt <= tick ? '0 : cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (tick) begin
                            snap   <= bus.DIN_VLD ? din_ch : samp;
                            k      <= '0;
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                    CALC: begin
                        win[k][ptr] <= cur_snap;
                        sum[k]      <= sum_new;
                        acc[k]      <= acc_new;
                        if (sat_hit) begin
                            sat_q[k] <= 1'b1;
                        end
                        if (k == KW'(CHANNELS - 1)) begin
                            // Publish on the last CALC edge so TILT_VLD lands in the DONE cycle;
                            // the last channel's fresh result is forwarded since acc updates on this same edge.
                            for (int unsigned i = 0; i < CHANNELS; i++) begin
                                tilt_q[i*ACC_WIDTH +: ACC_WIDTH] <= (i == CHANNELS - 1) ? acc_new : acc[i];
                            end
                            tilt_vld_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    DONE: begin
                        ptr    <= (DEPTH > 1) ? ptr + 1'b1 : '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    // A tick must never arrive while a calculation is still in flight.
    tick_only_in_idle: assert property (@(posedge CLK) disable iff (!RST_N)
        !(tick && !bus.ZERO && state != IDLE));

    assign bus.TILT     = tilt_q;
    assign bus.TILT_VLD = tilt_vld_q;
    assign bus.SAT      = sat_q;
    assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_gyro_tilt_integrator.sv
// Directed bench for gyro_tilt_integrator: dut0 (24-bit tilt) and dut1 (17-bit tilt, saturation).
module tb_gyro_tilt_integrator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gyro_tilt_integrator_if #(.CHANNELS(3), .WIDTH(16), .ACC_WIDTH(24)) if0 ();
    gyro_tilt_integrator_if #(.CHANNELS(3), .WIDTH(16), .ACC_WIDTH(17)) if1 ();

    gyro_tilt_integrator #(
        .CHANNELS(3), .WIDTH(16), .ACC_WIDTH(24), .AVG_LOG2(2),
        .TICK_DIV(8), .DB_LO(-42), .DB_HI(10)
    ) dut0 (.CLK(clk), .RST_N(rst_n), .bus(if0));

    gyro_tilt_integrator #(
        .CHANNELS(3), .WIDTH(16), .ACC_WIDTH(17), .AVG_LOG2(2),
        .TICK_DIV(8), .DB_LO(-42), .DB_HI(10)
    ) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

    function automatic int tilt0(input int ch);
        logic signed [23:0] v;
        v = if0.TILT[ch*24 +: 24];
        return int'(v);
    endfunction

    function automatic int tilt1(input int ch);
        logic signed [16:0] v;
        v = if1.TILT[ch*17 +: 17];
        return int'(v);
    endfunction

    task automatic set_din0(input int c0, input int c1, input int c2);
        if0.DIN = {16'(c2), 16'(c1), 16'(c0)};
    endtask

    // Called at a negedge; leaves the caller at a later negedge.
    task automatic pulse_vld0;
        if0.DIN_VLD = 1'b1;
        @(negedge clk);
        if0.DIN_VLD = 1'b0;
    endtask

    task automatic pulse_zero0;
        if0.ZERO = 1'b1;
        @(negedge clk);
        if0.ZERO = 1'b0;
    endtask

    task automatic wait_vld(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((which == 0 && if0.TILT_VLD === 1'b1) || (which == 1 && if1.TILT_VLD === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        int n;
        @(negedge clk);
        checks++; if (if0.TILT !== '0) begin failures++; $display("FAIL reset_tilt: got %h expected 0", if0.TILT); end
        checks++; if (if0.TILT_VLD !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", if0.TILT_VLD); end
        checks++; if (if0.SAT !== 3'b000) begin failures++; $display("FAIL reset_sat: got %b expected 000", if0.SAT); end
        checks++; if (if0.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", if0.BUSY); end
        rst_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if0.TILT_VLD === 1'b1) begin n = i; break; end
        end
        // release cycle counts as cycle 1: tick in cycle 8, pulse in cycle 12 (11th negedge)
        checks++; if (n != 11) begin failures++; $display("FAIL reset_latency: got %0d expected 11", n); end
        set_din0(100, 0, 0);
        pulse_vld0();
        wait_vld(0, ok);
        checks++; if (!ok || tilt0(0) != 25) begin failures++; $display("FAIL reset_pre_tilt: got %0d vld=%0d expected 25", tilt0(0), ok); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.BUSY === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL reset_busy_rise: got 0 expected 1"); end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (if0.TILT !== '0) begin failures++; $display("FAIL async_tilt: got %h expected 0", if0.TILT); end
        checks++; if (if0.BUSY !== 1'b0) begin failures++; $display("FAIL async_busy: got %b expected 0", if0.BUSY); end
        checks++; if (if0.TILT_VLD !== 1'b0 || if0.SAT !== 3'b000) begin failures++; $display("FAIL async_vld_sat: got vld=%b sat=%b expected 0/000", if0.TILT_VLD, if0.SAT); end
        @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if0.TILT_VLD === 1'b1) begin n = i; break; end
        end
        checks++; if (n != 11) begin failures++; $display("FAIL reset2_latency: got %0d expected 11", n); end
    endtask

    task automatic test_ramp;
        bit ok;
        int exp_t[5] = '{25, 75, 150, 250, 350};
        set_din0(100, 0, 0);
        pulse_vld0();
        for (int i = 0; i < 5; i++) begin
            wait_vld(0, ok);
            checks++; if (!ok || tilt0(0) != exp_t[i]) begin failures++; $display("FAIL ramp_ch0[%0d]: got %0d vld=%0d expected %0d", i, tilt0(0), ok, exp_t[i]); end
            checks++; if (tilt0(1) != 0 || tilt0(2) != 0) begin failures++; $display("FAIL ramp_ch12[%0d]: got %0d/%0d expected 0/0", i, tilt0(1), tilt0(2)); end
        end
        checks++; if (if0.SAT !== 3'b000) begin failures++; $display("FAIL ramp_sat: got %b expected 000", if0.SAT); end
    endtask

    task automatic test_deadband;
        bit ok;
        int exp_t[5] = '{0, 0, 0, -42, -84};
        set_din0(0, -40, 0);
        pulse_vld0();
        pulse_zero0();
        for (int i = 0; i < 5; i++) begin
            wait_vld(0, ok);
            checks++; if (!ok || tilt0(1) != 0) begin failures++; $display("FAIL db40_ch1[%0d]: got %0d vld=%0d expected 0", i, tilt0(1), ok); end
        end
        set_din0(0, -42, 0);
        pulse_vld0();
        pulse_zero0();
        for (int i = 0; i < 5; i++) begin
            wait_vld(0, ok);
            checks++; if (!ok || tilt0(1) != exp_t[i]) begin failures++; $display("FAIL db42_ch1[%0d]: got %0d vld=%0d expected %0d", i, tilt0(1), ok, exp_t[i]); end
        end
    endtask

    task automatic test_zero;
        bit ok;
        bit seen;
        set_din0(100, 0, 0);
        pulse_vld0();
        pulse_zero0();
        wait_vld(0, ok);
        checks++; if (!ok || tilt0(0) != 25) begin failures++; $display("FAIL zero_pre: got %0d vld=%0d expected 25", tilt0(0), ok); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.BUSY === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL zero_busy_rise: got 0 expected 1"); end
        @(negedge clk);
        // now in CALC k=1
        pulse_zero0();
        checks++; if (if0.TILT !== '0 || if0.SAT !== 3'b000 || if0.BUSY !== 1'b0) begin failures++; $display("FAIL zero_clear: got tilt=%h sat=%b busy=%b expected 0", if0.TILT, if0.SAT, if0.BUSY); end
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (if0.TILT_VLD !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL zero_abort_vld: got 1 expected 0"); end
        wait_vld(0, ok);
        checks++; if (!ok || tilt0(0) != 25) begin failures++; $display("FAIL zero_restart: got %0d vld=%0d expected 25", tilt0(0), ok); end
    endtask

    task automatic test_bypass;
        bit ok;
        set_din0(0, 0, 0);
        pulse_vld0();
        pulse_zero0();
        // counter is 0 here; 7 more cycles reaches the tick cycle
        repeat (7) @(negedge clk);
        set_din0(400, 0, 0);
        if0.DIN_VLD = 1'b1;
        @(negedge clk);
        if0.DIN_VLD = 1'b0;
        set_din0(0, 0, 0);
        wait_vld(0, ok);
        checks++; if (!ok || tilt0(0) != 100) begin failures++; $display("FAIL bypass_ch0: got %0d vld=%0d expected 100", tilt0(0), ok); end
    endtask

    task automatic test_saturation;
        bit ok;
        int exp_a[4] = '{8191, 24574, 49149, 65535};
        int exp_b[4] = '{65535, 65535, 49150, 16382};
        logic sat_a[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        if1.DIN = {16'sh7FFF, 16'd0, 16'd0};
        if1.DIN_VLD = 1'b1;
        @(negedge clk);
        if1.DIN_VLD = 1'b0;
        if1.ZERO = 1'b1;
        @(negedge clk);
        if1.ZERO = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_vld(1, ok);
            checks++; if (!ok || tilt1(2) != exp_a[i]) begin failures++; $display("FAIL sat_up_ch2[%0d]: got %0d vld=%0d expected %0d", i, tilt1(2), ok, exp_a[i]); end
            checks++; if (if1.SAT[2] !== sat_a[i]) begin failures++; $display("FAIL sat_up_flag[%0d]: got %b expected %b", i, if1.SAT[2], sat_a[i]); end
        end
        if1.DIN = {16'sh8000, 16'd0, 16'd0};
        if1.DIN_VLD = 1'b1;
        @(negedge clk);
        if1.DIN_VLD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_vld(1, ok);
            checks++; if (!ok || tilt1(2) != exp_b[i]) begin failures++; $display("FAIL sat_down_ch2[%0d]: got %0d vld=%0d expected %0d", i, tilt1(2), ok, exp_b[i]); end
            checks++; if (if1.SAT !== 3'b100) begin failures++; $display("FAIL sat_sticky[%0d]: got %b expected 100", i, if1.SAT); end
        end
        if1.ZERO = 1'b1;
        @(negedge clk);
        if1.ZERO = 1'b0;
        checks++; if (if1.SAT !== 3'b000 || if1.TILT !== '0) begin failures++; $display("FAIL sat_zero: got sat=%b tilt=%h expected 0", if1.SAT, if1.TILT); end
    endtask

    initial begin
        if0.DIN_VLD = 1'b0; if0.DIN = '0; if0.ZERO = 1'b0;
        if1.DIN_VLD = 1'b0; if1.DIN = '0; if1.ZERO = 1'b0;
        test_reset();
        test_ramp();
        test_deadband();
        test_zero();
        test_bypass();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
